// File: rtl/common_pkg.sv
// common_pkg
// Shared types and constants for the tiny CPU.
//   sys_state_t  : sequencer state encoding consumed by the memory front end
//   SPI_CMD_*    : SPI SRAM opcodes
//   mem_phase_t  : phase of an SPI SRAM transaction
//   mem_op_t     : kind of transaction latched at request time
package common_pkg;

  typedef enum logic [3:0] {
    STATE_RESET,
    STATE_FETCH,
    STATE_FETCH_WAIT,
    STATE_DECODE,
    STATE_EXECUTE,
    STATE_LOAD_MEM,
    STATE_LOAD_MEM_WAIT,
    STATE_STORE_MEM,
    STATE_STORE_MEM_WAIT,
    STATE_WRITEBACK,
    STATE_HALT
  } sys_state_t;

  localparam logic [7:0] SPI_CMD_READ  = 8'h03;
  localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

  // Shift register width: 8 command + 16 address + 16 data bits.
  localparam int SPI_SHIFT_W = 40;
  // Receive history: enough for one fetched instruction.
  localparam int SPI_RX_W    = 16;

  localparam logic [4:0] CMD_BITS   = 5'd8;
  localparam logic [4:0] ADDR_BITS  = 5'd16;
  localparam logic [4:0] INST_BITS  = 5'd16;
  localparam logic [4:0] BYTE_BITS  = 5'd8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    DONE
  } mem_phase_t;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } mem_op_t;

endpackage

// File: rtl/mem_controller_spi_shift_engine.sv
// spi_shift_engine
// Mode-0 SPI bit engine. Each start loads a left-aligned tx word and a bit
// count; every bit takes two clk_in cycles (SCLK low with MOSI updated, then
// SCLK high with MISO sampled at the closing edge).
//   clk_in, reset_in : clock, synchronous active-high reset
//   start_in         : load tx_word_in / bit_count_in at this edge
//   bit_count_in     : number of bits in this burst
//   tx_word_in       : bits to send, MSB at bit SPI_SHIFT_W-1
//   spi_miso_in      : serial data in
//   rx_word_out      : last SPI_RX_W received bits, including the bit being
//                      sampled at the current edge (valid while done_out)
//   done_out         : high in the final SCLK-high cycle of the burst
//   spi_sclk_out     : registered SCLK
//   spi_mosi_out     : registered MOSI
module spi_shift_engine
  import common_pkg::*;
(
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic                   start_in,
  input  logic [4:0]             bit_count_in,
  input  logic [SPI_SHIFT_W-1:0] tx_word_in,
  input  logic                   spi_miso_in,
  output logic [SPI_RX_W-1:0]    rx_word_out,
  output logic                   done_out,
  output logic                   spi_sclk_out,
  output logic                   spi_mosi_out
);

  logic [SPI_SHIFT_W-1:0] shift_q, shift_d;
  logic [SPI_RX_W-2:0]    rx_hist_q, rx_hist_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   sclk_q, sclk_d;
  logic                   active_q, active_d;
  logic                   sample;

  // The edge closing an SCLK-high cycle is where MISO is captured.
  assign sample      = active_q & sclk_q;
  assign done_out    = sample & (cnt_q == 5'd1);
  // Exposing the in-flight bit lets the caller register a complete word at
  // the same edge that ends the burst, with no extra cycle.
  assign rx_word_out = {rx_hist_q, spi_miso_in};

  always_comb begin
    shift_d   = shift_q;
    rx_hist_d = rx_hist_q;
    cnt_d     = cnt_q;
    sclk_d    = sclk_q;
    active_d  = active_q;
    if (sample) begin
      rx_hist_d = rx_word_out[SPI_RX_W-2:0];
      shift_d   = {shift_q[SPI_SHIFT_W-2:0], 1'b0};
      cnt_d     = cnt_q - 5'd1;
      sclk_d    = 1'b0;
      if (done_out) active_d = 1'b0;
    end else if (active_q) begin
      sclk_d = 1'b1;
    end
    // A new burst starts back-to-back with the one just finishing.
    if (start_in) begin
      shift_d  = tx_word_in;
      cnt_d    = bit_count_in;
      sclk_d   = 1'b0;
      active_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      shift_q   <= '0;
      rx_hist_q <= '0;
      cnt_q     <= '0;
      sclk_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      rx_hist_q <= rx_hist_d;
      cnt_q     <= cnt_d;
      sclk_q    <= sclk_d;
      active_q  <= active_d;
    end
  end

  assign spi_sclk_out = sclk_q;
  assign spi_mosi_out = shift_q[SPI_SHIFT_W-1];

endmodule

// File: rtl/mem_controller.sv
// mem_controller
// Serial memory front end: turns fetch / load / store requests from the
// sequencer into SPI SRAM READ/WRITE transactions.
//   clk_in, reset_in        : clock, synchronous active-high reset
//   seq_state_in            : sequencer state, decoded only in IDLE
//   pc_in, data_addr_in     : fetch / load-store byte address
//   store_data_in           : byte to store
//   inst_out, read_data_out : last fetched instruction / loaded byte (held)
//   inst_fetch_done_out     : one-cycle pulse at fetch completion
//   data_read_done_out      : one-cycle pulse at load completion
//   mem_busy_out            : high while a transaction is in progress
//   spi_*                   : SPI SRAM pins (mode 0, MSB first)
//
// state | meaning
// IDLE  | CS high, waiting for a request
// CMD   | shifting the 8-bit opcode
// ADDR  | shifting the 16-bit address
// DATA  | 16 (fetch) or 8 (load/store) data bits
// DONE  | CS high, results and done pulse valid
module mem_controller
  import common_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int INST_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  sys_state_t        seq_state_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] data_addr_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic [INST_W-1:0] inst_out,
  output logic [DATA_W-1:0] read_data_out,
  output logic              inst_fetch_done_out,
  output logic              data_read_done_out,
  output logic              mem_busy_out,
  output logic              spi_cs_n_out,
  output logic              spi_sclk_out,
  output logic              spi_mosi_out,
  input  logic              spi_miso_in
);

  mem_phase_t        phase_q, phase_d;
  mem_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              fetch_done_q, fetch_done_d;
  logic              read_done_q, read_done_d;
  logic              busy_q, busy_d;
  logic              cs_n_q, cs_n_d;

  logic                   eng_start;
  logic [4:0]             eng_count;
  logic [SPI_SHIFT_W-1:0] eng_tx;
  logic [SPI_RX_W-1:0]    eng_rx;
  logic                   eng_done;
  logic                   req;

  spi_shift_engine u_engine (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (eng_start),
    .bit_count_in (eng_count),
    .tx_word_in   (eng_tx),
    .spi_miso_in  (spi_miso_in),
    .rx_word_out  (eng_rx),
    .done_out     (eng_done),
    .spi_sclk_out (spi_sclk_out),
    .spi_mosi_out (spi_mosi_out)
  );

  always_comb begin
    phase_d      = phase_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_d       = inst_q;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    cs_n_d       = cs_n_q;
    fetch_done_d = 1'b0;
    read_done_d  = 1'b0;
    eng_start    = 1'b0;
    eng_count    = '0;
    eng_tx       = '0;
    req          = 1'b0;

    case (phase_q)
      IDLE: begin
        case (seq_state_in)
          STATE_FETCH: begin
            req    = 1'b1;
            op_d   = OP_FETCH;
            addr_d = pc_in;
          end
          STATE_LOAD_MEM: begin
            req    = 1'b1;
            op_d   = OP_LOAD;
            addr_d = data_addr_in;
          end
          STATE_STORE_MEM: begin
            req     = 1'b1;
            op_d    = OP_STORE;
            addr_d  = data_addr_in;
            wdata_d = store_data_in;
          end
          default: req = 1'b0;
        endcase
        if (req) begin
          phase_d   = CMD;
          busy_d    = 1'b1;
          cs_n_d    = 1'b0;
          eng_start = 1'b1;
          eng_count = CMD_BITS;
          eng_tx    = {(op_d == OP_STORE) ? SPI_CMD_WRITE : SPI_CMD_READ, 32'd0};
        end
      end
      CMD: begin
        if (eng_done) begin
          phase_d   = ADDR;
          eng_start = 1'b1;
          eng_count = ADDR_BITS;
          eng_tx    = {addr_q, 24'd0};
        end
      end
      ADDR: begin
        if (eng_done) begin
          phase_d   = DATA;
          eng_start = 1'b1;
          eng_count = (op_q == OP_FETCH) ? INST_BITS : BYTE_BITS;
          // Reads keep MOSI low through the data phase.
          eng_tx    = (op_q == OP_STORE) ? {wdata_q, 32'd0} : '0;
        end
      end
      DATA: begin
        if (eng_done) begin
          phase_d = DONE;
          busy_d  = 1'b0;
          cs_n_d  = 1'b1;
          if (op_q == OP_FETCH) begin
            inst_d       = eng_rx[INST_W-1:0];
            fetch_done_d = 1'b1;
          end else if (op_q == OP_LOAD) begin
            rdata_d     = eng_rx[DATA_W-1:0];
            read_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        phase_d = IDLE;
      end
      default: begin
        phase_d = IDLE;
        busy_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      phase_q      <= IDLE;
      op_q         <= OP_FETCH;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_q       <= '0;
      rdata_q      <= '0;
      fetch_done_q <= 1'b0;
      read_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      cs_n_q       <= 1'b1;
    end else begin
      phase_q      <= phase_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_q       <= inst_d;
      rdata_q      <= rdata_d;
      fetch_done_q <= fetch_done_d;
      read_done_q  <= read_done_d;
      busy_q       <= busy_d;
      cs_n_q       <= cs_n_d;
    end
  end

  assign inst_out            = inst_q;
  assign read_data_out       = rdata_q;
  assign inst_fetch_done_out = fetch_done_q;
  assign data_read_done_out  = read_done_q;
  assign mem_busy_out        = busy_q;
  assign spi_cs_n_out        = cs_n_q;

endmodule

// File: doc/mem_controller.md
# mem_controller

Serial memory front end for the tiny CPU. It watches the sequencer state and turns instruction fetch, data load and data store requests into transactions on an external SPI SRAM. It returns the fetched instruction or loaded byte to the core and drives the `inst_fetch_done_in`, `data_read_done_in` and `mem_busy_in` handshakes that the sequencer consumes. It sits between the sequencer/datapath and the chip's SPI pins.

## Interface
- `ADDR_W`, default 16: SPI SRAM address width, always sent as 16 bits.
- `INST_W`, default 16: instruction width, fetched as 2 bytes.
- `DATA_W`, default 8: data width, 1 byte.

Ports:
- `clk_in` in 1: system clock. One clock domain.
- `reset_in` in 1: reset, synchronous and active-high.
- `seq_state_in` in `sys_state_t`: current sequencer state.
- `pc_in` in `ADDR_W`: instruction byte address.
- `data_addr_in` in `ADDR_W`: load/store address.
- `store_data_in` in `DATA_W`: byte to store.
- `inst_out` out `INST_W`: last fetched instruction, held.
- `read_data_out` out `DATA_W`: last loaded byte, held.
- `inst_fetch_done_out` out 1: one-cycle pulse when the fetch completes.
- `data_read_done_out` out 1: one-cycle pulse when the load completes.
- `mem_busy_out` out 1: high while a transaction is in progress.
- `spi_cs_n_out` out 1: chip select, active low.
- `spi_sclk_out` out 1: SPI clock, mode 0.
- `spi_mosi_out` out 1: serial data out, MSB first.
- `spi_miso_in` in 1: serial data in.

## Operation
- Requests are decoded in IDLE only, from `seq_state_in`:
  - `STATE_FETCH`: READ (0x03), address `pc_in`, 16 data bits.
  - `STATE_LOAD_MEM`: READ, address `data_addr_in`, 8 data bits.
  - `STATE_STORE_MEM`: WRITE (0x02), address `data_addr_in`, data `store_data_in`.
  - Any other state: no action.
- Address and store data are latched in the request cycle and are not re-sampled afterwards.
- FSM states: IDLE → CMD (8 bits) → ADDR (16 bits) → DATA (8 or 16 bits) → DONE → IDLE.
- A bit counter reloads on every phase change.
- Fetch byte order: the first byte received is `inst_out[15:8]`. The SRAM auto-increments, so only one address is sent. `pc_in` = 0xFFFF wraps to 0x0000 on the second byte; this is device behaviour and no special handling is needed.
- `inst_out` and `read_data_out` update only in DONE of their own transaction type and hold otherwise.
- A request decoded while not in IDLE is ignored. The sequencer never issues one.
- Reset values:
  - `spi_cs_n_out` = 1
  - `spi_sclk_out` = 0, `spi_mosi_out` = 0
  - `mem_busy_out` = 0
  - both done pulses = 0
  - `inst_out` = 0, `read_data_out` = 0
  - FSM = IDLE
- Reset mid-transaction: on the next edge, CS is high, SCLK is low, the FSM is in IDLE and no done pulse is issued. Partial read data is discarded and the output registers return to 0.

## Timing
- Request sampled at cycle T.
  - `mem_busy_out` and CS low from T+1.
- Each bit takes 2 cycles:
  - First cycle: SCLK low, MOSI updated.
  - Second cycle: SCLK high, MISO sampled at the end of that cycle.
- Transaction length N bits: fetch 40, load 32, store 32.
- The last SCLK-high cycle is T+2N. In DONE at T+2N+1:
  - CS high, `mem_busy_out` low.
  - Done pulse high for exactly that cycle.
  - Output registers valid from that cycle.
- Resulting timing:
  - Fetch: done at T+81.
  - Load: done at T+65.
  - Store: busy falls at T+65.
- The sequencer leaves `STATE_STORE_MEM` at T+1, so it sees busy = 1 in `STATE_STORE_MEM_WAIT`. This is mandatory; busy must not be late.
- SCLK frequency is `clk_in`/2. There is at least one CS-high cycle (DONE) between transactions.
- All outputs are registered, with no combinational path from `spi_miso_in`.

## Structure
- `common_pkg`:
  - Already holds `sys_state_t`.
  - Add `SPI_CMD_READ` = 8'h03 and `SPI_CMD_WRITE` = 8'h02.
  - Add the `mem_phase_t` enum (IDLE, CMD, ADDR, DATA, DONE).
- One sub-module, `spi_shift_engine`:
  - 40-bit load/shift register, bit counter and SCLK toggle.
  - Inputs: start, bit count, tx word.
  - Outputs: rx word, done.
- `mem_controller` itself keeps request decode, the phase FSM and the output registers.

## Test plan
- Fetch at `pc_in` = 0x1234 with SRAM model byte 0x1234 = 0xA5 and byte 0x1235 = 0x3C:
  - MOSI carries 0x03, 0x12, 0x34.
  - `inst_out` = 0xA53C and `inst_fetch_done_out` pulses at T+81 only.
- Load from 0x00FF = 0x5A: `read_data_out` = 0x5A, done at T+65, `inst_out` unchanged.
- Store 0xC3 to 0x8001:
  - MOSI carries 0x02, 0x80, 0x01, 0xC3.
  - Busy is high T+1..T+64 and low at T+65.
  - The SRAM model holds 0xC3.
- Fetch at 0xFFFF with byte 0xFFFF = 0x11 and byte 0x0000 = 0x22: `inst_out` = 0x1122.
- Assert `reset_in` at T+20 of a fetch:
  - Next edge: CS = 1, SCLK = 0, busy = 0, `inst_out` = 0, no done pulse.
  - A fresh fetch afterwards completes normally.
- Drive `STATE_LOAD_MEM` at T+10 during a fetch: it is ignored, and only the fetch done pulse occurs.
